// File: rtl/round_stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// round_stopwatch_pkg
// Shared definitions for the round stopwatch:
//   - state_e     : 2-bit FSM state encoding (IDLE=0, RUN=1, HOLD=2, DONE=3)
//   - BCD_W       : width of one BCD digit
//   - MS_MAX      : last value of the 1 ms sub-tenths counter (0..99)
//   - LIMIT_MIN/MAX : legal range of the round limit in whole seconds
//   - bcd2_to_bin : converts a two-digit BCD seconds value to binary
// -----------------------------------------------------------------------------
package round_stopwatch_pkg;

  localparam int BCD_W     = 4;
  localparam int MS_MAX    = 99;
  localparam int LIMIT_MIN = 1;
  localparam int LIMIT_MAX = 99;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Two BCD digits (tens, ones) to a 7-bit binary value, max 99.
  function automatic logic [6:0] bcd2_to_bin(input logic [BCD_W-1:0] tens,
                                             input logic [BCD_W-1:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/round_stopwatch_if.sv
// -----------------------------------------------------------------------------
// round_stopwatch_if
// Groups the request inputs, tick-timer controls and display/status outputs
// of the round stopwatch.
//   master : game-side driver (drives ms_pulse/start/stop/clear, reads status)
//   slave  : the stopwatch itself
// Signals:
//   ms_pulse, start, stop, clear         requests, one clk cycle wide
//   timer_enable, timer_clear            controls to the 1 ms tick timer
//   sec_tens, sec_ones, tenths           BCD display digits
//   running, timeout, state              status
// -----------------------------------------------------------------------------
interface round_stopwatch_if;
  import round_stopwatch_pkg::*;

  logic             ms_pulse;
  logic             start;
  logic             stop;
  logic             clear;
  logic             timer_enable;
  logic             timer_clear;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] sec_ones;
  logic [BCD_W-1:0] tenths;
  logic             running;
  logic             timeout;
  logic [1:0]       state;

  modport master (
    output ms_pulse, start, stop, clear,
    input  timer_enable, timer_clear, sec_tens, sec_ones, tenths,
           running, timeout, state
  );

  modport slave (
    input  ms_pulse, start, stop, clear,
    output timer_enable, timer_clear, sec_tens, sec_ones, tenths,
           running, timeout, state
  );

endinterface

// File: rtl/round_stopwatch_bcd_digit_cnt.sv
// -----------------------------------------------------------------------------
// bcd_digit_cnt
// One registered BCD digit (0..9) with synchronous clear and increment.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : zero the digit (wins over inc_i)
//   inc_i     : advance the digit by one, wrapping 9 -> 0
//   digit_o   : current digit value
//   carry_o   : combinational, high when this inc_i wraps the digit 9 -> 0;
//               feeds inc_i of the next more significant digit
// -----------------------------------------------------------------------------
module bcd_digit_cnt
  import round_stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             carry_o
);

  localparam logic [BCD_W-1:0] DIGIT_MAX = BCD_W'(9);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  assign carry_o = inc_i && !clr_i && (digit_q == DIGIT_MAX);
  assign digit_o = digit_q;

  always_comb begin
    // NOTE: default assignment first so every path assigns digit_d; without it
    // a missing branch would infer a latch.
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (inc_i) begin
      digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + BCD_W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/round_stopwatch.sv
// -----------------------------------------------------------------------------
// round_stopwatch
// Per-round game stopwatch downstream of the 1 ms tick timer. Gates and clears
// the timer, counts 1 ms pulses into a BCD SS.t display value, freezes it on a
// player stop and pulses timeout when the round limit LIMIT_S.0 is reached.
// Parameters:
//   LIMIT_S : round limit in whole seconds, 1..99
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   sw       : round_stopwatch_if.slave (requests in, timer controls, BCD
//              digits and status out; all outputs registered)
// -----------------------------------------------------------------------------
module round_stopwatch
  import round_stopwatch_pkg::*;
#(
  parameter int LIMIT_S = 30
) (
  input  logic              clk,
  input  logic              rst,
  round_stopwatch_if.slave  sw
);

  state_e           state_q;
  state_e           state_d;
  logic [6:0]       ms_cnt_q;
  logic [6:0]       ms_cnt_d;
  logic             timer_enable_q;
  logic             timer_clear_q;
  logic             running_q;
  logic             timeout_q;

  logic             count_en;
  logic             ms_wrap;
  logic             limit_hit;
  logic             tenths_carry;
  logic             ones_carry;
  logic             tens_carry;
  logic [BCD_W-1:0] tenths_w;
  logic [BCD_W-1:0] ones_w;
  logic [BCD_W-1:0] tens_w;

  // Pulses count only in RUN; clear has top priority and suppresses counting.
  assign count_en = (state_q == ST_RUN) && sw.ms_pulse && !sw.clear;
  assign ms_wrap  = count_en && (ms_cnt_q == 7'(MS_MAX));

  // The limit can only be reached on a carry into the seconds digits (tenths
  // wraps to 0), so compare the seconds value that carry is about to produce.
  // This lets DONE, timeout and the final digits all land on the same edge.
  assign limit_hit = tenths_carry &&
                     (bcd2_to_bin(tens_w, ones_w) + 7'd1 == 7'(LIMIT_S));

  bcd_digit_cnt u_tenths (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sw.clear),
    .inc_i   (ms_wrap),
    .digit_o (tenths_w),
    .carry_o (tenths_carry)
  );

  bcd_digit_cnt u_sec_ones (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sw.clear),
    .inc_i   (tenths_carry),
    .digit_o (ones_w),
    .carry_o (ones_carry)
  );

  bcd_digit_cnt u_sec_tens (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sw.clear),
    .inc_i   (ones_carry),
    .digit_o (tens_w),
    .carry_o (tens_carry)
  );

  always_comb begin
    state_d  = state_q;
    ms_cnt_d = ms_cnt_q;

    if (count_en) begin
      ms_cnt_d = (ms_cnt_q == 7'(MS_MAX)) ? 7'd0 : ms_cnt_q + 7'd1;
    end

    if (sw.clear) begin
      state_d  = ST_IDLE;
      ms_cnt_d = 7'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A pulse arriving with start is not counted: count_en needs RUN.
          if (sw.start) begin
            state_d  = ST_RUN;
            ms_cnt_d = 7'd0;
          end
        end
        ST_RUN: begin
          // Reaching the limit overrides a simultaneous stop; a pulse that
          // arrives with stop is still counted above.
          if (limit_hit) begin
            state_d = ST_DONE;
          end else if (sw.stop) begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Resume keeps digits and ms count; the tick timer zeroed itself
          // while disabled, so no timer_clear here.
          if (sw.start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ms_cnt_q       <= 7'd0;
      timer_enable_q <= 1'b0;
      timer_clear_q  <= 1'b0;
      running_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ms_cnt_q       <= ms_cnt_d;
      // Registered from the next state so these track the state output
      // exactly, with no extra cycle of lag.
      running_q      <= (state_d == ST_RUN);
      timer_enable_q <= (state_d == ST_RUN);
      timer_clear_q  <= sw.clear || ((state_q == ST_IDLE) && sw.start);
      timeout_q      <= limit_hit;
    end
  end

  assign sw.state        = state_q;
  assign sw.running      = running_q;
  assign sw.timer_enable = timer_enable_q;
  assign sw.timer_clear  = timer_clear_q;
  assign sw.timeout      = timeout_q;
  assign sw.tenths       = tenths_w;
  assign sw.sec_ones     = ones_w;
  assign sw.sec_tens     = tens_w;

  // Simulation-only checks: legal limit, and the display never rolls past
  // 99.9 because the limit stops the count first.
  a_limit_range : assert property (@(posedge clk)
      (LIMIT_S >= LIMIT_MIN) && (LIMIT_S <= LIMIT_MAX))
    else $error("round_stopwatch: LIMIT_S=%0d outside %0d..%0d",
                LIMIT_S, LIMIT_MIN, LIMIT_MAX);

  a_no_tens_wrap : assert property (@(posedge clk) disable iff (rst)
      !tens_carry)
    else $error("round_stopwatch: seconds tens digit wrapped");

endmodule

// File: doc/round_stopwatch.md
# round_stopwatch

Per-round game stopwatch that sits directly downstream of the 1 ms tick timer. It gates and clears that timer, counts its 1 ms pulses into a BCD seconds/tenths value for the 7-segment display path, and freezes the value when a player stops the round. It raises a one-cycle timeout when a configurable round limit is reached.

## Interface
- LIMIT_S, default 30: round limit in whole seconds, legal range 1..99.
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- ms_pulse  in  1  1 ms tick from the tick timer, one clk cycle wide.
- start  in  1  one-cycle request: begin or resume the round.
- stop  in  1  one-cycle request: freeze the round (player buzz).
- clear  in  1  one-cycle request: abort and zero.
- timer_enable  out  1  enable to the tick timer.
- timer_clear  out  1  clear to the tick timer, one cycle wide.
- sec_tens  out  4  BCD seconds tens digit.
- sec_ones  out  4  BCD seconds ones digit.
- tenths  out  4  BCD tenths-of-second digit.
- running  out  1  high while in RUN.
- timeout  out  1  one-cycle pulse when the limit is reached.
- state  out  2  current FSM state, for debug and the game FSM.

## Operation
- The FSM has four states: IDLE=0, RUN=1, HOLD=2, DONE=3.
- Request priority is clear > stop > start. A request that is illegal in the current state is ignored.
- In any state, clear moves the FSM to IDLE, zeroes all digits and the internal ms count, and asserts timer_clear.
- IDLE + start: go to RUN. Zero the internal ms count and assert timer_clear for that cycle.
- RUN + ms_pulse: increment the count.
- RUN + stop: go to HOLD.
- RUN, count reaches LIMIT_S.0: go to DONE and pulse timeout.
- HOLD + start: resume RUN. Digits and ms count are kept. No timer_clear is issued; the tick timer self-zeros while disabled.
- DONE: only clear leaves this state.
- Count chain:
  - ms_cnt is 7-bit binary, 0..99.
  - When ms_cnt wraps 99→0, tenths increments.
  - When tenths wraps 9→0, sec_ones increments.
  - When sec_ones wraps 9→0, sec_tens increments.
  - The display never exceeds LIMIT_S.0.
- Limit compare: when the carry into the seconds digits produces sec_tens*10+sec_ones == LIMIT_S with tenths=0, the FSM goes to DONE in the same cycle the digits update.
- Boundary cases:
  - RUN with stop and ms_pulse in the same cycle: the pulse is counted, then the FSM enters HOLD.
  - RUN with stop in the same cycle the limit is reached: the FSM enters DONE, timeout=1, and stop is ignored.
  - start and ms_pulse in the same cycle in IDLE: the pulse is not counted.
  - ms_pulse outside RUN is ignored.
  - rst at any time: all state is cleared immediately, with no wait for clk.

## Timing
- Reset values: state=IDLE, all digits 0, running=0, timeout=0, timer_enable=0, timer_clear=0.
- All outputs are registered.
- timer_enable is high in the cycle after the FSM enters RUN, and low in the cycle after it leaves RUN.
- timer_clear is high for exactly the one cycle after the triggering start or clear request.
- Digits update 1 cycle after the sampled ms_pulse.
- timeout is asserted in the same cycle that the digits show LIMIT_S.0 and state shows DONE.
- running equals (state==RUN).
- Requests are sampled once per cycle. Back-to-back requests on consecutive cycles are each honoured.

## Structure
- Shared package holds:
  - the 2-bit state encoding constants;
  - BCD_W=4 and MS_MAX=99;
  - LIMIT range constants (1 and 99) for the assertion.
- Sub-module bcd_digit_cnt: one BCD digit with inc and clr inputs and a carry output; carry is high when the digit wraps 9→0 on inc. It is instantiated three times (tenths, sec_ones, sec_tens) with ripple carry.
- The FSM, the ms_cnt counter, the limit compare and the timer-control registers live in the top module.
- Simulation-only assertion: LIMIT_S must be within 1..99.

## Test plan
- Reset then start, then 1500 ms_pulses → digits 0,1,5; running=1; timer_enable=1 one cycle after start; timer_clear high for 1 cycle.
- LIMIT_S=3, start, 3000 pulses → digits 0,3,0; timeout high for exactly 1 cycle; state=DONE; further pulses and start leave the digits unchanged.
- Start, 750 pulses, stop, 200 pulses, start, 250 pulses → digits 0,1,0. HOLD has frozen the value, and timer_enable is low during HOLD.
- Stop and ms_pulse in the same cycle at ms_cnt=99, tenths=4 → tenths=5 and state=HOLD.
- clear asserted while in RUN at 12.3 s → digits 0,0,0; state=IDLE; timer_clear=1 for 1 cycle; timer_enable=0.
- rst asserted mid-RUN between clock edges → all outputs 0 immediately. After rst is released, the first start restarts counting from 0.
